// File: rtl/ap_prof_pkg.sv
// ap_prof_pkg: shared record type, flag bit positions and FSM states for the transaction profiler.
package ap_prof_pkg;
  localparam int P_CNT_W = 32;
  localparam int P_ID_W = 16;
  localparam int FLAG_INCOMPLETE = 0;
  localparam int FLAG_ORPHAN = 1;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} prof_state_t;
  typedef struct packed {
    logic [P_ID_W-1:0] id;
    logic [P_CNT_W-1:0] start_ts;
    logic [P_CNT_W-1:0] latency;
    logic [P_CNT_W-1:0] interval;
    logic [1:0] flags;
  } prof_rec_t;
endpackage

// File: rtl/prof_sync_fifo.sv
// prof_sync_fifo: synchronous FIFO; a write while full is accepted only if a read frees a slot that cycle.
module prof_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic wr,
  input  logic [W-1:0] din,
  input  logic rd,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_rd, do_wr;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clock) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
    end
    if (do_wr) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/ap_txn_profiler.sv
// ap_txn_profiler: turns ap_ctrl handshakes into per-transaction records on a valid/ready stream.
module ap_txn_profiler
  import ap_prof_pkg::*;
#(
  parameter int CNT_W = P_CNT_W,
  parameter int ID_W = P_ID_W,
  parameter int INFLIGHT = 4,
  parameter int OUT_DEPTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic ap_start,
  input  logic ap_ready,
  input  logic ap_done,
  input  logic ap_continue,
  input  logic finish,
  output logic rec_valid,
  input  logic rec_ready,
  output logic [ID_W-1:0] rec_id,
  output logic [CNT_W-1:0] rec_start_ts,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_interval,
  output logic [1:0] rec_flags,
  output logic [15:0] drop_cnt,
  output logic busy,
  output logic done_all
);
  prof_state_t state;
  prof_rec_t rec, head;
  logic [CNT_W-1:0] now, last_ts, if_dout;
  logic [ID_W-1:0] id;
  logic start_pending, have_last;
  logic if_full, if_empty, out_full, out_empty;
  logic start_ev, done_ev, flush, orphan, if_pop, if_push, start_drop, gen, out_push, rec_drop;
  assign start_ev = state == RUN && !finish && ap_start && !start_pending;
  assign done_ev = state != DONE && ap_done && ap_continue;
  assign flush = state == DRAIN && !done_ev && !if_empty && !out_full;
  assign orphan = done_ev && if_empty && !start_ev;
  assign if_pop = (done_ev || flush) && !if_empty;
  // A start coinciding with done on an empty queue bypasses the queue entirely.
  assign if_push = start_ev && !(done_ev && if_empty) && (!if_full || if_pop);
  assign start_drop = start_ev && !(done_ev && if_empty) && if_full && !if_pop;
  assign gen = done_ev || flush;
  assign out_push = gen && !out_full;
  assign rec_drop = gen && out_full;
  // Records leave in start order, so the interval is measured against the previous record's start.
  always_comb begin
    rec = '0;
    rec.id = id;
    rec.start_ts = if_empty ? now : if_dout;
    rec.latency = if_empty ? {{(CNT_W-1){1'b0}}, start_ev} : now - if_dout + 1'b1;
    rec.interval = (orphan || !have_last) ? '0 : rec.start_ts - last_ts;
    rec.flags[FLAG_INCOMPLETE] = flush;
    rec.flags[FLAG_ORPHAN] = orphan;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      now <= '0;
      id <= '0;
      last_ts <= '0;
      have_last <= 1'b0;
      start_pending <= 1'b0;
      drop_cnt <= '0;
    end else begin
      now <= now + 1'b1;
      start_pending <= start_ev ? !ap_ready : (ap_ready ? 1'b0 : start_pending);
      state <= (state == RUN && finish) ? DRAIN : (state == DRAIN && if_empty) ? DONE : state;
      if (gen) id <= id + 1'b1;
      if (gen && !orphan) begin
        last_ts <= rec.start_ts;
        have_last <= 1'b1;
      end
      if ((start_drop || rec_drop) && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end
  prof_sync_fifo #(.W(CNT_W), .DEPTH(INFLIGHT)) u_inflight (
    .clock(clock), .reset(reset), .wr(if_push), .din(now), .rd(if_pop),
    .dout(if_dout), .full(if_full), .empty(if_empty)
  );
  prof_sync_fifo #(.W($bits(prof_rec_t)), .DEPTH(OUT_DEPTH)) u_out (
    .clock(clock), .reset(reset), .wr(out_push), .din(rec), .rd(rec_ready),
    .dout(head), .full(out_full), .empty(out_empty)
  );
  assign rec_valid = !out_empty;
  assign rec_id = head.id;
  assign rec_start_ts = head.start_ts;
  assign rec_latency = head.latency;
  assign rec_interval = head.interval;
  assign rec_flags = head.flags;
  assign busy = !if_empty || state == DRAIN;
  assign done_all = state == DONE;
endmodule

// File: tb/tb_ap_txn_profiler.sv
// tb_ap_txn_profiler: directed stimulus with a scoreboard queue checked by an independent record monitor.
module tb_ap_txn_profiler;
  import ap_prof_pkg::*;
  logic clock = 0, reset = 1;
  logic ap_start = 0, ap_ready = 0, ap_done = 0, ap_continue = 1, finish = 0, rec_ready = 1;
  logic rec_valid, busy, done_all;
  logic [15:0] rec_id, drop_cnt;
  logic [31:0] rec_start_ts, rec_latency, rec_interval;
  logic [1:0] rec_flags;
  logic [31:0] cyc = 0;
  int checks = 0, failures = 0;
  prof_rec_t exp_q[$];

  ap_txn_profiler dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .finish(finish), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_id(rec_id), .rec_start_ts(rec_start_ts), .rec_latency(rec_latency),
    .rec_interval(rec_interval), .rec_flags(rec_flags), .drop_cnt(drop_cnt), .busy(busy),
    .done_all(done_all)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= reset ? 32'd0 : cyc + 32'd1;

  always @(negedge clock) begin
    prof_rec_t got, e;
    if (!reset && rec_valid && rec_ready) begin
      got = {rec_id, rec_start_ts, rec_latency, rec_interval, rec_flags};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_record id=%0d ts=%0d lat=%0d iv=%0d flags=%b", got.id, got.start_ts, got.latency, got.interval, got.flags);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL record got id=%0d ts=%0d lat=%0d iv=%0d flags=%b exp id=%0d ts=%0d lat=%0d iv=%0d flags=%b",
                   got.id, got.start_ts, got.latency, got.interval, got.flags, e.id, e.start_ts, e.latency, e.interval, e.flags);
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_cyc(int c);
    for (int i = 0; i < 2000 && cyc != c; i++) tick();
    if (cyc != c) begin
      $display("FAIL wait_cyc got=%0d exp=%0d", cyc, c);
      $fatal(1, "cycle wait expired");
    end
  endtask

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic expect_rec(int id, int ts, int lat, int iv, int fl);
    prof_rec_t r;
    r.id = 16'(id);
    r.start_ts = 32'(ts);
    r.latency = 32'(lat);
    r.interval = 32'(iv);
    r.flags = 2'(fl);
    exp_q.push_back(r);
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    tick(2);
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1;
    {ap_start, ap_ready, ap_done, finish} = '0;
    rec_ready = 1;
    tick(2);
    reset = 0;
  endtask

  task automatic pulse_start(int c);
    wait_cyc(c);
    ap_start = 1;
    ap_ready = 1;
    tick();
    ap_start = 0;
    ap_ready = 0;
  endtask

  task automatic pulse_done(int c);
    wait_cyc(c);
    ap_done = 1;
    tick();
    ap_done = 0;
  endtask

  initial begin
    tick(3);
    do_reset();
    chk("reset_valid", 64'(rec_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_drop", 64'(drop_cnt), 64'd0);
    chk("reset_done_all", 64'(done_all), 64'd0);

    // single transaction
    pulse_start(10);
    expect_rec(0, 10, 5, 0, 0);
    pulse_done(14);
    drain("single_drain");

    // pipelined, plus start and done together on a non-empty queue
    do_reset();
    pulse_start(10);
    pulse_start(12);
    pulse_start(14);
    chk("pipe_busy", 64'(busy), 64'd1);
    expect_rec(0, 10, 11, 0, 0);
    pulse_done(20);
    expect_rec(1, 12, 11, 2, 0);
    pulse_done(22);
    wait_cyc(24);
    {ap_start, ap_ready, ap_done} = 3'b111;
    expect_rec(2, 14, 11, 2, 0);
    tick();
    {ap_start, ap_ready, ap_done} = 3'b000;
    expect_rec(3, 24, 5, 10, 0);
    pulse_done(28);
    drain("pipe_drain");
    chk("pipe_idle", 64'(busy), 64'd0);

    // held ap_start counts once
    do_reset();
    wait_cyc(10);
    ap_start = 1;
    wait_cyc(15);
    ap_ready = 1;
    tick();
    ap_start = 0;
    ap_ready = 0;
    tick();
    chk("held_busy", 64'(busy), 64'd1);
    expect_rec(0, 10, 11, 0, 0);
    pulse_done(20);
    drain("held_drain");
    chk("held_one_txn", 64'(busy), 64'd0);

    // back-pressure: 10 bypass transactions into an 8-deep output FIFO
    do_reset();
    rec_ready = 0;
    wait_cyc(10);
    {ap_start, ap_ready, ap_done} = 3'b111;
    tick(10);
    {ap_start, ap_ready, ap_done} = 3'b000;
    tick();
    chk("bp_drop", 64'(drop_cnt), 64'd2);
    chk("bp_valid", 64'(rec_valid), 64'd1);
    for (int k = 0; k < 8; k++) expect_rec(k, 10 + k, 1, k == 0 ? 0 : 1, 0);
    rec_ready = 1;
    drain("bp_drain");

    // finish with two transactions in flight; a start on the finish cycle is ignored
    do_reset();
    pulse_start(30);
    pulse_start(32);
    expect_rec(0, 30, 12, 0, 1);
    expect_rec(1, 32, 11, 2, 1);
    wait_cyc(40);
    {ap_start, ap_ready, finish} = 3'b111;
    tick();
    {ap_start, ap_ready, finish} = 3'b000;
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_not_done", 64'(done_all), 64'd0);
    wait_cyc(46);
    chk("done_all", 64'(done_all), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    pulse_start(47);
    pulse_done(49);
    drain("finish_drain");
    chk("done_sticky", 64'(done_all), 64'd1);

    // orphan, in-flight overflow, then reset mid-operation
    do_reset();
    rec_ready = 0;
    pulse_done(5);
    tick();
    chk("orphan_valid", 64'(rec_valid), 64'd1);
    chk("orphan_flags", 64'(rec_flags), 64'd2);
    chk("orphan_lat", 64'(rec_latency), 64'd0);
    chk("orphan_ts", 64'(rec_start_ts), 64'd5);
    for (int k = 0; k < 5; k++) pulse_start(10 + 2 * k);
    tick();
    chk("full_drop", 64'(drop_cnt), 64'd1);
    chk("full_busy", 64'(busy), 64'd1);
    do_reset();
    chk("rst_valid", 64'(rec_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    pulse_start(3);
    expect_rec(0, 3, 2, 0, 0);
    pulse_done(4);
    drain("rst_id_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
